// File: rtl/spi_reg_bank_if.sv
// Byte stream between the SPI mode-3 byte slave and the register bank.
// The slave side presents each received byte with a one-cycle valid pulse
// and picks up the byte to shift out on the next SPI byte.
interface spi_reg_bank_if;
    logic [7:0] rx;
    logic       rxValid;
    logic [7:0] tx;

    // Driven by the SPI byte slave (or a testbench standing in for it).
    modport master (
        output rx,
        output rxValid,
        input  tx
    );

    // Used by the register bank.
    modport slave (
        input  rx,
        input  rxValid,
        output tx
    );
endinterface

// File: rtl/spi_reg_bank.sv
// Framed read/write command parser and register bank behind an SPI byte
// slave. The first byte of a frame is {RW, A[6:0]}; following bytes are
// written to (RW=0) or read from (RW=1) an auto-incrementing address.
module spi_reg_bank #(
    parameter int         ADDR_W    = 4,
    parameter logic [7:0] IDLE_BYTE = 8'hA5,
    parameter logic [7:0] ERR_BYTE  = 8'hEE
) (
    input  logic                      sysClk,
    input  logic                      usrReset_n,
    input  logic                      SS,
    spi_reg_bank_if.slave             bus,
    output logic [8*(2**ADDR_W)-1:0]  regs,
    output logic                      wrStb,
    output logic [ADDR_W-1:0]         wrAddr,
    output logic [7:0]                wrData,
    output logic                      err
);

    localparam int NREGS = 2**ADDR_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_WRITE,
        ST_READ,
        ST_ERR
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic              r_ss_meta;
    logic              r_ss_sync;
    logic              r_ss_act_d;
    logic              w_ss_act;
    logic              w_ss_rise;
    logic              w_ss_fall;

    logic [7:0]        r_regs [NREGS];
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] w_ptr_nxt;
    logic [ADDR_W-1:0] w_ptr_inc;
    logic [7:0]        r_tx;
    logic [7:0]        w_tx_nxt;
    logic              r_err;
    logic              w_err_nxt;
    logic              w_do_write;
    logic              r_wr_stb;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [7:0]        r_wr_data;

    logic [ADDR_W-1:0] w_cmd_addr;
    logic [6:0]        w_cmd_hi;

    assign w_ss_act   = ~r_ss_sync;
    assign w_ss_rise  = w_ss_act & ~r_ss_act_d;
    assign w_ss_fall  = ~w_ss_act & r_ss_act_d;
    assign w_ptr_inc  = r_ptr + ADDR_W'(1);
    assign w_cmd_addr = bus.rx[ADDR_W-1:0];
    assign w_cmd_hi   = bus.rx[6:0] >> ADDR_W;

    // Two-flop synchronizer on SS plus a delayed copy for edge detection.
    // The flops reset to "select active" so that a reset in the middle of a
    // frame cannot manufacture a frame start: SS must go inactive and then
    // active again before the parser listens to bytes.
    always_ff @(posedge sysClk or negedge usrReset_n) begin
        if (!usrReset_n) begin
            r_ss_meta  <= 1'b0;
            r_ss_sync  <= 1'b0;
            r_ss_act_d <= 1'b1;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge value of its neighbours.
            r_ss_meta  <= SS;
            r_ss_sync  <= r_ss_meta;
            r_ss_act_d <= w_ss_act;
        end
    end

    // Frame state register.
    always_ff @(posedge sysClk or negedge usrReset_n) begin
        if (!usrReset_n) r_state <= ST_IDLE;
        else             r_state <= w_state_nxt;
    end

    // Next-state, pointer, tx and error decisions; SS falling wins over any
    // byte arriving in the same cycle.
    always_comb begin
        // NOTE: every signal gets a default before the branches, otherwise a
        // path that does not assign it would infer a latch.
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_tx_nxt    = r_tx;
        w_err_nxt   = r_err;
        w_do_write  = 1'b0;

        if (w_ss_fall) begin
            w_state_nxt = ST_IDLE;
            w_tx_nxt    = IDLE_BYTE;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_ss_rise) begin
                        w_state_nxt = ST_CMD;
                        w_err_nxt   = 1'b0;
                        w_tx_nxt    = IDLE_BYTE;
                    end
                end
                ST_CMD: begin
                    if (bus.rxValid) begin
                        if (w_cmd_hi != 7'd0) begin
                            w_state_nxt = ST_ERR;
                            w_err_nxt   = 1'b1;
                            w_tx_nxt    = ERR_BYTE;
                        end else begin
                            w_ptr_nxt = w_cmd_addr;
                            if (bus.rx[7]) begin
                                w_state_nxt = ST_READ;
                                w_tx_nxt    = r_regs[w_cmd_addr];
                            end else begin
                                w_state_nxt = ST_WRITE;
                            end
                        end
                    end
                end
                ST_WRITE: begin
                    if (bus.rxValid) begin
                        w_do_write = 1'b1;
                        w_ptr_nxt  = w_ptr_inc;
                    end
                end
                ST_READ: begin
                    if (bus.rxValid) begin
                        w_ptr_nxt = w_ptr_inc;
                        w_tx_nxt  = r_regs[w_ptr_inc];
                    end
                end
                ST_ERR: begin
                    w_tx_nxt = ERR_BYTE;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_tx_nxt    = IDLE_BYTE;
                end
            endcase
        end
    end

    // Register bank, pointer, tx byte, error flag and write reporting.
    always_ff @(posedge sysClk or negedge usrReset_n) begin
        if (!usrReset_n) begin
            // NOTE: the bank is reset on purpose because its contents are
            // architecturally visible after reset; this keeps it in flops
            // rather than a RAM macro, which is fine at this size.
            for (int k = 0; k < NREGS; k++) r_regs[k] <= 8'h00;
            r_ptr     <= '0;
            r_tx      <= IDLE_BYTE;
            r_err     <= 1'b0;
            r_wr_stb  <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= 8'h00;
        end else begin
            r_ptr    <= w_ptr_nxt;
            r_tx     <= w_tx_nxt;
            r_err    <= w_err_nxt;
            r_wr_stb <= w_do_write;
            if (w_do_write) begin
                r_regs[r_ptr] <= bus.rx;
                r_wr_addr     <= r_ptr;
                r_wr_data     <= bus.rx;
            end
        end
    end

    // Flatten the bank: register k occupies bits [8k+7:8k].
    for (genvar k = 0; k < NREGS; k++) begin : g_flat
        assign regs[8*k +: 8] = r_regs[k];
    end

    assign bus.tx = r_tx;
    assign wrStb  = r_wr_stb;
    assign wrAddr = r_wr_addr;
    assign wrData = r_wr_data;
    assign err    = r_err;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed testbench for spi_reg_bank: drives SS and the byte stream the
// way the SPI byte slave would and checks tx, the bank and write reporting
// against hand-computed values.
module tb_spi_reg_bank;

    localparam int ADDR_W = 4;
    localparam int NREGS  = 2**ADDR_W;

    logic                  sysClk;
    logic                  usrReset_n;
    logic                  SS;
    logic [8*NREGS-1:0]    regs;
    logic                  wrStb;
    logic [ADDR_W-1:0]     wrAddr;
    logic [7:0]            wrData;
    logic                  err;

    spi_reg_bank_if bus ();

    spi_reg_bank #(
        .ADDR_W    (ADDR_W),
        .IDLE_BYTE (8'hA5),
        .ERR_BYTE  (8'hEE)
    ) dut (
        .sysClk     (sysClk),
        .usrReset_n (usrReset_n),
        .SS         (SS),
        .bus        (bus.slave),
        .regs       (regs),
        .wrStb      (wrStb),
        .wrAddr     (wrAddr),
        .wrData     (wrData),
        .err        (err)
    );

    initial sysClk = 1'b0;
    always #5 sysClk = ~sysClk;

    int tests_run = 0;
    int tests_failed = 0;
    int stb_count = 0;
    int stb_base;

    logic [7:0] exp_regs [NREGS];

    // Count every cycle in which wrStb is high, sampled mid-cycle.
    always @(negedge sysClk) begin
        if (wrStb === 1'b1) stb_count++;
    end

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_bank(input string tag);
        logic [8*NREGS-1:0] exp_flat;
        for (int k = 0; k < NREGS; k++) exp_flat[8*k +: 8] = exp_regs[k];
        tests_run++;
        assert (regs === exp_flat) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, regs, exp_flat);
        end
    endtask

    function automatic logic [7:0] reg_at(input int k);
        return regs[8*k +: 8];
    endfunction

    // Advance n clock edges; inputs change and outputs are read 1 ns after
    // each rising edge.
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge sysClk);
            #1;
        end
    endtask

    // Present one byte for exactly one clock; on return the edge that
    // consumed it has passed, so one-cycle-latency results are visible.
    task automatic send_byte(input logic [7:0] b);
        bus.rx      = b;
        bus.rxValid = 1'b1;
        idle(1);
        bus.rxValid = 1'b0;
        bus.rx      = 8'h00;
    endtask

    task automatic frame_start();
        SS = 1'b0;
        idle(4);
    endtask

    task automatic frame_end();
        SS = 1'b1;
        idle(4);
    endtask

    task automatic clear_model();
        for (int k = 0; k < NREGS; k++) exp_regs[k] = 8'h00;
    endtask

    initial begin
        usrReset_n  = 1'b0;
        SS          = 1'b1;
        bus.rx      = 8'h00;
        bus.rxValid = 1'b0;
        clear_model();
        idle(3);

        // Reset state.
        check8("rst_tx", bus.tx, 8'hA5);
        check8("rst_err", 8'(err), 8'h00);
        check8("rst_wrstb", 8'(wrStb), 8'h00);
        check8("rst_wraddr", 8'(wrAddr), 8'h00);
        check8("rst_wrdata", wrData, 8'h00);
        check_bank("rst_bank");
        usrReset_n = 1'b1;
        idle(5);

        // A byte with no frame open is ignored.
        send_byte(8'h42);
        idle(2);
        check8("idle_tx", bus.tx, 8'hA5);
        check_bank("idle_bank");
        check8("idle_nostb", 8'(stb_count), 8'd0);

        // Write frame from address 3.
        stb_base = stb_count;
        frame_start();
        send_byte(8'h03);
        check8("wr_cmd_tx", bus.tx, 8'hA5);
        check8("wr_cmd_nostb", 8'(wrStb), 8'h00);
        idle(3);
        send_byte(8'h11);
        exp_regs[3] = 8'h11;
        check8("wr1_stb", 8'(wrStb), 8'h01);
        check8("wr1_addr", 8'(wrAddr), 8'h03);
        check8("wr1_data", wrData, 8'h11);
        check8("wr1_reg3", reg_at(3), 8'h11);
        idle(1);
        check8("wr1_stb_one_cycle", 8'(wrStb), 8'h00);
        idle(2);
        send_byte(8'h22);
        exp_regs[4] = 8'h22;
        check8("wr2_stb", 8'(wrStb), 8'h01);
        check8("wr2_addr", 8'(wrAddr), 8'h04);
        check8("wr2_data", wrData, 8'h22);
        check8("wr_tx", bus.tx, 8'hA5);
        frame_end();
        check_bank("wr_bank");
        check8("wr_stb_count", 8'(stb_count - stb_base), 8'd2);

        // Write wrapping from address 15 to 0.
        stb_base = stb_count;
        frame_start();
        send_byte(8'h0F);
        idle(3);
        send_byte(8'hAA);
        exp_regs[15] = 8'hAA;
        check8("wrap1_addr", 8'(wrAddr), 8'h0F);
        check8("wrap1_data", wrData, 8'hAA);
        idle(3);
        send_byte(8'hBB);
        exp_regs[0] = 8'hBB;
        check8("wrap2_addr", 8'(wrAddr), 8'h00);
        check8("wrap2_data", wrData, 8'hBB);
        frame_end();
        check_bank("wrap_bank");
        check8("wrap_stb_count", 8'(stb_count - stb_base), 8'd2);

        // Read from address 3 with two dummies, then past into unwritten reg5.
        stb_base = stb_count;
        frame_start();
        send_byte(8'h83);
        check8("rd_cmd_tx", bus.tx, 8'h11);
        idle(3);
        send_byte(8'h00);
        check8("rd1_tx", bus.tx, 8'h22);
        idle(3);
        send_byte(8'h00);
        check8("rd2_tx", bus.tx, 8'h00);
        frame_end();
        check8("rd_end_tx", bus.tx, 8'hA5);
        check8("rd_nostb", 8'(stb_count - stb_base), 8'd0);

        // Read wrapping from address 15 to 0.
        frame_start();
        send_byte(8'h8F);
        check8("rdwrap_cmd_tx", bus.tx, 8'hAA);
        idle(3);
        send_byte(8'h00);
        check8("rdwrap_tx", bus.tx, 8'hBB);
        frame_end();

        // Out-of-range address puts the frame in error.
        stb_base = stb_count;
        frame_start();
        send_byte(8'h30);
        check8("bad_err", 8'(err), 8'h01);
        check8("bad_tx", bus.tx, 8'hEE);
        idle(3);
        send_byte(8'h55);
        check8("bad_tx_held", bus.tx, 8'hEE);
        check8("bad_nostb_now", 8'(wrStb), 8'h00);
        frame_end();
        check8("bad_err_sticky", 8'(err), 8'h01);
        check8("bad_end_tx", bus.tx, 8'hA5);
        check_bank("bad_bank");
        check8("bad_nostb", 8'(stb_count - stb_base), 8'd0);

        // Next frame clears the error and writes normally.
        frame_start();
        check8("next_err_clr", 8'(err), 8'h00);
        send_byte(8'h01);
        idle(3);
        send_byte(8'h66);
        exp_regs[1] = 8'h66;
        check8("next_reg1", reg_at(1), 8'h66);
        frame_end();
        check_bank("next_bank");

        // Reset in the middle of a write frame; the rest of that frame is dead.
        frame_start();
        send_byte(8'h05);
        idle(3);
        send_byte(8'h77);
        check8("abort_pre_reg5", reg_at(5), 8'h77);
        idle(2);
        usrReset_n = 1'b0;
        idle(1);
        clear_model();
        check_bank("abort_rst_bank");
        check8("abort_rst_tx", bus.tx, 8'hA5);
        usrReset_n = 1'b1;
        idle(3);
        stb_base = stb_count;
        send_byte(8'h88);
        idle(3);
        send_byte(8'h99);
        idle(3);
        check8("abort_nostb", 8'(stb_count - stb_base), 8'd0);
        check_bank("abort_bank");
        frame_end();
        frame_start();
        send_byte(8'h02);
        idle(3);
        send_byte(8'h44);
        exp_regs[2] = 8'h44;
        frame_end();
        check_bank("abort_recover_bank");

        // Data byte arriving in the same cycle SS is seen going inactive.
        stb_base = stb_count;
        frame_start();
        send_byte(8'h07);
        idle(3);
        SS = 1'b1;
        idle(2);
        send_byte(8'hCC);
        check8("coinc_nostb_now", 8'(wrStb), 8'h00);
        check8("coinc_tx", bus.tx, 8'hA5);
        idle(3);
        check8("coinc_reg7", reg_at(7), 8'h00);
        check8("coinc_nostb", 8'(stb_count - stb_base), 8'd0);
        check_bank("coinc_bank");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
